// File: rtl/de0_nano_i2c_target.sv
// I2C target with four byte registers, also readable and writable from the Nios II
// over an Avalon-MM slave; SDA is driven open-drain through sda_oe.
module de0_nano_i2c_target #(
    parameter logic [6:0] I2C_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busy
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RACK      = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_d_r;
    logic                   sda_d_r;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise_s;
    logic                   scl_fall_s;
    logic                   start_s;
    logic                   stop_s;
    logic [3:0]             state_r;
    logic [3:0]             bit_cnt_r;
    logic [7:0]             shift_r;
    logic [1:0]             ptr_r;
    logic                   rw_r;
    logic                   ack_r;
    logic [7:0]             regs_r [4];
    logic [7:0]             byte_s;
    logic                   i2c_we_s;
    logic                   av_we_s;
    logic                   unused_wdata_s;

    // Pin synchronizers plus one delay flop used for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_r <= '1;
            sda_sync_r <= '1;
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
            scl_d_r    <= scl_sync_r[SYNC_STAGES-1];
            sda_d_r    <= sda_sync_r[SYNC_STAGES-1];
        end
    end

    // Bus events, write strobes and the combinational Avalon read path
    always_comb begin
        scl_s          = scl_sync_r[SYNC_STAGES-1];
        sda_s          = sda_sync_r[SYNC_STAGES-1];
        scl_rise_s     = scl_s & ~scl_d_r;
        scl_fall_s     = ~scl_s & scl_d_r;
        start_s        = scl_s & scl_d_r & sda_d_r & ~sda_s;
        stop_s         = scl_s & scl_d_r & ~sda_d_r & sda_s;
        byte_s         = {shift_r[6:0], sda_s};
        av_we_s        = chipselect & ~write_n;
        i2c_we_s       = (state_r == ST_WDATA) & scl_rise_s & (bit_cnt_r == 4'd7);
        readdata       = {24'h000000, regs_r[address]};
        unused_wdata_s = ^writedata[31:8];
    end

    // Protocol FSM: sample on SCL rise, change sda_oe only on SCL fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            ptr_r     <= 2'd0;
            rw_r      <= 1'b0;
            ack_r     <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
        end else if (start_s) begin
            state_r   <= ST_ADDR;
            bit_cnt_r <= 4'd0;
            sda_oe    <= 1'b0;
            busy      <= 1'b1;
        end else if (stop_s) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
        end else if (scl_rise_s) begin
            case (state_r)
                ST_ADDR: begin
                    if (bit_cnt_r < 4'd8) begin
                        shift_r   <= byte_s;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end else begin
                        shift_r <= shift_r;
                    end
                    if (bit_cnt_r == 4'd7) begin
                        rw_r <= sda_s;
                        if (byte_s[7:1] != I2C_ADDR) begin
                            state_r <= ST_IGNORE;
                        end else begin
                            state_r <= ST_ADDR;
                        end
                    end else begin
                        rw_r <= rw_r;
                    end
                end
                ST_PTR: begin
                    if (bit_cnt_r < 4'd8) begin
                        shift_r   <= byte_s;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end else begin
                        shift_r <= shift_r;
                    end
                    if (bit_cnt_r == 4'd7) begin
                        ptr_r <= byte_s[1:0];
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                ST_WDATA: begin
                    if (bit_cnt_r < 4'd8) begin
                        shift_r   <= byte_s;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end else begin
                        shift_r <= shift_r;
                    end
                    // the register write itself happens in the register file on this edge
                    if (bit_cnt_r == 4'd7) begin
                        ptr_r <= ptr_r + 2'd1;
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                ST_RDATA: bit_cnt_r <= bit_cnt_r + 4'd1;
                ST_RACK:  ack_r     <= ~sda_s;
                default:  ack_r     <= ack_r;
            endcase
        end else if (scl_fall_s) begin
            case (state_r)
                ST_ADDR: begin
                    if (bit_cnt_r == 4'd8) begin
                        sda_oe  <= 1'b1;
                        state_r <= ST_ADDR_ACK;
                    end else begin
                        sda_oe  <= 1'b0;
                    end
                end
                ST_PTR: begin
                    if (bit_cnt_r == 4'd8) begin
                        sda_oe  <= 1'b1;
                        state_r <= ST_PTR_ACK;
                    end else begin
                        sda_oe  <= 1'b0;
                    end
                end
                ST_WDATA: begin
                    if (bit_cnt_r == 4'd8) begin
                        sda_oe  <= 1'b1;
                        state_r <= ST_WDATA_ACK;
                    end else begin
                        sda_oe  <= 1'b0;
                    end
                end
                ST_ADDR_ACK: begin
                    bit_cnt_r <= 4'd0;
                    if (rw_r) begin
                        shift_r <= regs_r[ptr_r];
                        sda_oe  <= ~regs_r[ptr_r][7];
                        state_r <= ST_RDATA;
                    end else begin
                        sda_oe  <= 1'b0;
                        state_r <= ST_PTR;
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    bit_cnt_r <= 4'd0;
                    sda_oe    <= 1'b0;
                    state_r   <= ST_WDATA;
                end
                ST_RDATA: begin
                    if (bit_cnt_r == 4'd8) begin
                        sda_oe  <= 1'b0;
                        ptr_r   <= ptr_r + 2'd1;
                        state_r <= ST_RACK;
                    end else begin
                        shift_r <= {shift_r[6:0], 1'b0};
                        sda_oe  <= ~shift_r[6];
                    end
                end
                ST_RACK: begin
                    bit_cnt_r <= 4'd0;
                    if (ack_r) begin
                        shift_r <= regs_r[ptr_r];
                        sda_oe  <= ~regs_r[ptr_r][7];
                        state_r <= ST_RDATA;
                    end else begin
                        sda_oe  <= 1'b0;
                        state_r <= ST_IGNORE;
                    end
                end
                default: sda_oe <= 1'b0;
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Register file: an Avalon write beats a same-cycle I2C write to the same byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (av_we_s && (address == i[1:0])) begin
                    regs_r[i] <= writedata[7:0];
                end else if (i2c_we_s && (ptr_r == i[1:0])) begin
                    regs_r[i] <= byte_s;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_de0_nano_i2c_target.sv
// Directed plus randomized bench for de0_nano_i2c_target: an I2C initiator model
// drives the pins while a transaction-level register/pointer model predicts results.
module tb_de0_nano_i2c_target;

    localparam int         SYNC = 2;
    localparam logic [6:0] TADDR = 7'h42;
    localparam int         Q = 5;

    logic        clk;
    logic        reset;
    logic        scl_m;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busy;

    logic [7:0]  mreg [4];
    logic [1:0]  mptr;
    logic [7:0]  wq [$];
    int          errors;
    int          checks;
    logic        mon_en;
    int          oe_hits;

    assign sda_line = sda_m & ~sda_oe;

    de0_nano_i2c_target #(.I2C_ADDR(TADDR), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
        .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_en && sda_oe) oe_hits = oe_hits + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1; clks(Q);
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b1; clks(Q);
        sda_m = 1'b1; clks(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    clks(Q);
        scl_m = 1'b1; clks(Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1; clks(2);
        b = sda_line; clks(Q - 2);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack_bit);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack_bit);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    task automatic av_write(input logic [1:0] a, input logic [7:0] d);
        address = a; writedata = {24'h5A5A5A, d}; chipselect = 1'b1; write_n = 1'b0;
        clks(1);
        chipselect = 1'b0; write_n = 1'b1;
        mreg[a] = d;
    endtask

    task automatic av_check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            address = 2'(i);
            #1;
            check(tag, readdata, {24'h000000, mreg[i]});
        end
    endtask

    // Write the bytes queued in wq starting at register pointer p
    task automatic i2c_write_regs(input logic [7:0] p, input bit glitch);
        logic a;
        i2c_start();
        check("busy_after_start", {31'b0, busy}, 32'h1);
        send_byte({TADDR, 1'b0}, a);
        check("waddr_ack", {31'b0, a}, 32'h0);
        send_byte(p, a);
        check("ptr_ack", {31'b0, a}, 32'h0);
        mptr = p[1:0];
        if (glitch) begin
            sda_m = 1'b0; clks(1);
            sda_m = 1'b1; clks(Q);
            check("glitch_busy", {31'b0, busy}, 32'h1);
            check("glitch_oe", {31'b0, sda_oe}, 32'h0);
        end
        foreach (wq[i]) begin
            send_byte(wq[i], a);
            check("wdata_ack", {31'b0, a}, 32'h0);
            mreg[mptr] = wq[i];
            mptr = mptr + 2'd1;
        end
        i2c_stop();
        check("busy_after_stop", {31'b0, busy}, 32'h0);
    endtask

    // Set the pointer, repeated START, then read n bytes (NACK on the last)
    task automatic i2c_read_regs(input logic [7:0] p, input int n);
        logic       a;
        logic [7:0] d;
        i2c_start();
        send_byte({TADDR, 1'b0}, a);
        check("raddr_w_ack", {31'b0, a}, 32'h0);
        send_byte(p, a);
        check("rptr_ack", {31'b0, a}, 32'h0);
        mptr = p[1:0];
        i2c_start();
        send_byte({TADDR, 1'b1}, a);
        check("raddr_r_ack", {31'b0, a}, 32'h0);
        for (int k = 0; k < n; k++) begin
            recv_byte(d, (k == n - 1));
            check("rdata", {24'h0, d}, {24'h0, mreg[mptr]});
            mptr = mptr + 2'd1;
        end
        check("released_after_nack", {31'b0, sda_oe}, 32'h0);
        i2c_stop();
        check("busy_after_rstop", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        logic a;
        int   n;
        errors = 0; checks = 0; mon_en = 1'b0; oe_hits = 0;
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        mptr = 2'd0;
        clks(3);
        check("rst_oe", {31'b0, sda_oe}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        av_check_all("rst_readdata");
        reset = 1'b0;
        clks(4);

        // Reset asserted while the target is driving the address ACK
        av_write(2'd0, 8'h3C);
        av_write(2'd2, 8'h77);
        i2c_start();
        for (int i = 7; i >= 1; i--) send_bit(TADDR[i-1]);
        send_bit(1'b0);
        sda_m = 1'b1; clks(Q);
        check("ack_driven", {31'b0, sda_oe}, 32'h1);
        scl_m = 1'b1; clks(2);
        reset = 1'b1;
        #1;
        check("midack_rst_oe", {31'b0, sda_oe}, 32'h0);
        check("midack_rst_busy", {31'b0, busy}, 32'h0);
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        @(negedge clk);
        av_check_all("midack_rst_readdata");
        scl_m = 1'b1; sda_m = 1'b1; clks(2);
        reset = 1'b0;
        clks(4);

        // Basic write: S,0x84,0x01,0xA5,0x5A,P
        wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h5A);
        i2c_write_regs(8'h01, 1'b0);
        av_check_all("write_regs");

        // Read with pointer wrap 3 -> 0
        av_write(2'd3, 8'hC3);
        i2c_read_regs(8'h03, 2);

        // Foreign address: no ACK, bus never pulled
        oe_hits = 0; mon_en = 1'b1;
        i2c_start();
        send_byte(8'h90, a);
        check("foreign_nack", {31'b0, a}, 32'h1);
        send_byte(8'h00, a);
        send_byte(8'hFF, a);
        i2c_stop();
        mon_en = 1'b0;
        check("foreign_oe_hits", 32'(oe_hits), 32'h0);
        check("foreign_busy", {31'b0, busy}, 32'h0);
        av_check_all("foreign_regs");

        // Same-cycle I2C write of 0x11 and Avalon write of 0x22 to REG0
        i2c_start();
        send_byte({TADDR, 1'b0}, a);
        check("coll_addr_ack", {31'b0, a}, 32'h0);
        send_byte(8'h00, a);
        check("coll_ptr_ack", {31'b0, a}, 32'h0);
        for (int i = 7; i >= 1; i--) send_bit(i == 4);
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1;
        repeat (SYNC) @(negedge clk);
        address = 2'd0; writedata = 32'h00000022; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        clks(Q - SYNC - 1);
        scl_m = 1'b0; clks(Q);
        recv_bit(a);
        check("coll_data_ack", {31'b0, a}, 32'h0);
        i2c_stop();
        mreg[0] = 8'h22;
        av_check_all("collision");

        // SDA glitch while SCL low must not look like START/STOP
        wq.delete(); wq.push_back(8'h96); wq.push_back(8'h0F);
        i2c_write_regs(8'h02, 1'b1);
        av_check_all("glitch_regs");

        // Randomized writes and reads against the model
        for (int it = 0; it < 4; it++) begin
            wq.delete();
            n = int'($urandom_range(1, 5));
            for (int k = 0; k < n; k++) wq.push_back(8'($urandom_range(0, 255)));
            i2c_write_regs(8'($urandom_range(0, 255)), 1'b0);
            if (it[0]) av_write(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            i2c_read_regs(8'($urandom_range(0, 255)), int'($urandom_range(1, 5)));
            av_check_all("rand_regs");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
